sar_search_4bits: RTL
=====================

SAR_SEARCH_4BITS -- requirements
Module: sar_search_4bits

Interface
REQ-001 Parameter SETTLE, default 1, sets the cycles cmp_probe is held before cmp_result is sampled; the legal range is 1..3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a search; accepted only in IDLE.
REQ-005 cmp_probe  output  4  trial value driven to the external comparator "a" input; the unknown value sits on the comparator "b" input.
REQ-006 cmp_result  input  3  comparator answer: [2] probe<unknown, [1] probe>unknown, [0] probe=unknown.
REQ-007 busy  output  1  high from the cycle after start is accepted until the cycle done is high.
REQ-008 done  output  1  one-cycle pulse marking the end of a search.
REQ-009 value  output  4  search result, valid from done until the next accepted start.
REQ-010 err  output  1  high with done when an illegal cmp_result was sampled; holds until the next accepted start.

Function
REQ-011 States SHALL be IDLE, PROBE, EVAL and FIN.
- IDLE -> PROBE on start=1.
- PROBE -> EVAL after SETTLE cycles in PROBE.
- EVAL -> PROBE, or -> FIN on the terminal conditions below.
- FIN -> IDLE unconditionally after 1 cycle.
REQ-012 On start accept: acc=0, bit index i=3, err=0; value is left unchanged until FIN.
REQ-013 In PROBE and EVAL, cmp_probe SHALL equal acc | (1<<i); in IDLE and FIN it SHALL equal acc.
REQ-014 In EVAL, cmp_result SHALL be sampled once and acted on as follows:
- 3'b100: acc |= 1<<i.
- 3'b010: bit i of acc stays 0.
- 3'b001: acc=trial, go to FIN (early termination).
REQ-015 In EVAL, any cmp_result that is not one-hot (000, 011, 101, 110, 111) SHALL set err=1 and go to FIN; acc is left unchanged.
REQ-016 After an EVAL with i=0 and no EQ, go to FIN; otherwise decrement i and go to PROBE.
REQ-017 In FIN: done=1, value=acc (registered), busy=0 in that cycle.
REQ-018 start is ignored while busy or in FIN; no queuing.
REQ-019 Worst-case latency with SETTLE=1: start sampled at edge 0, done high in cycle 9 (4 x (SETTLE+1) + 1).
REQ-020 An EQ result at bit i SHALL terminate early with done (3-i) x (SETTLE+1) + SETTLE + 2 cycles after start is sampled.
REQ-021 Unknown=0 SHALL complete with all four probes answered GT and value=0, err=0.
REQ-022 All outputs SHALL be registered; no combinational path from cmp_result or start to any output.

Reset
REQ-023 When rst_n=0 at a clk edge: state=IDLE, acc=0, i=3, value=0, cmp_probe=0, busy=0, done=0, err=0.
REQ-024 Reset asserted mid-search SHALL abort the search without a done pulse; the first start after release begins a fresh search.
REQ-025 start high in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-026 Shared package sar_pkg SHALL hold:
- the state enum (IDLE, PROBE, EVAL, FIN);
- result bit index constants CMP_LT=2, CMP_GT=1, CMP_EQ=0;
- the data width constant W=4.
REQ-027 One sub-module, cmp_result_decode, SHALL map cmp_result to {lt, gt, eq, illegal}; everything else stays in sar_search_4bits.

Verification
REQ-028 The bench SHALL use a behavioural 4-bit comparator model driven by cmp_probe and an unknown U. The required responses, with SETTLE=1, are:
- V1: U=9, start pulse -> probes 8,12,10,9; EQ at 9; done in cycle 9, value=9, err=0.
- V2: U=0 -> probes 8,4,2,1 all GT; done in cycle 9, value=0.
- V3: U=8 -> first probe 8 returns EQ; done in cycle 3, value=8, busy high only in cycles 1-2.
- V4: force cmp_result=3'b110 at the second EVAL -> done with err=1, value=8 (U=13, acc after bit 3); the next start clears err.
- V5: rst_n=0 during the third PROBE -> no done pulse; all outputs 0 the next cycle; a new search with U=5 -> value=5.
- V6: start held high through a search with U=3, plus SETTLE=3 -> exactly one search per IDLE accept; done in cycle 17 (4 x 4 + 1).

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the 4-bit successive-approximation search.
// The comparator result bit positions live here so the decoder and its users agree.
package sar_pkg;

  localparam int unsigned W = 4;

  // Bit positions inside cmp_result.
  localparam int unsigned CMP_LT = 2;
  localparam int unsigned CMP_GT = 1;
  localparam int unsigned CMP_EQ = 0;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    EVAL,
    FIN
  } state_e;

  // One-hot mask selecting the trial bit for the current search step.
  function automatic logic [W-1:0] bit_mask(input logic [1:0] idx);
    return W'(1) << idx;
  endfunction

endpackage

// File: rtl/cmp_result_decode.sv
// Classifies the external comparator answer; anything that is not exactly one-hot
// is flagged illegal so the search can stop with an error.
module cmp_result_decode
  import sar_pkg::*;
(
  input  logic [2:0] cmp_result,
  output logic       lt,
  output logic       gt,
  output logic       eq,
  output logic       illegal
);

  always_comb begin
    lt      = 1'b0;
    gt      = 1'b0;
    eq      = 1'b0;
    illegal = 1'b0;
    unique case (cmp_result)
      3'(1 << CMP_LT): lt      = 1'b1;
      3'(1 << CMP_GT): gt      = 1'b1;
      3'(1 << CMP_EQ): eq      = 1'b1;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_search_4bits.sv
// Successive-approximation search for a 4-bit unknown using an external comparator.
// Every output is a flop loaded from the next-state values, so nothing is combinational.
module sar_search_4bits
  import sar_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] cmp_probe,
  input  logic [2:0]   cmp_result,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] value,
  output logic         err
);

  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [1:0]   idx_q, idx_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] probe_q, probe_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] value_q, value_d;
  logic         err_q, err_d;

  logic         res_lt, res_gt, res_eq, res_illegal;
  logic [W-1:0] trial_q, trial_d;
  logic         searching_d;

  cmp_result_decode u_decode (
    .cmp_result (cmp_result),
    .lt         (res_lt),
    .gt         (res_gt),
    .eq         (res_eq),
    .illegal    (res_illegal)
  );

  assign trial_q = acc_q | bit_mask(idx_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PROBE;
          acc_d   = '0;
          idx_d   = 2'd3;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      PROBE: begin
        // Hold the trial on the comparator for SETTLE cycles before trusting its answer.
        if (cnt_q == 2'(SETTLE - 1)) begin
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      EVAL: begin
        if (res_illegal) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (res_eq) begin
          acc_d   = trial_q;
          state_d = FIN;
        end else begin
          if (res_lt && !res_gt) begin
            acc_d = trial_q;
          end
          if (idx_q == 2'd0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - 2'd1;
            cnt_d   = '0;
            state_d = PROBE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flops are loaded from the state being entered so they line up with it.
  always_comb begin
    trial_d     = acc_d | bit_mask(idx_d);
    searching_d = (state_d == PROBE) || (state_d == EVAL);
    probe_d     = searching_d ? trial_d : acc_d;
    busy_d      = searching_d;
    done_d      = (state_d == FIN);
    value_d     = (state_d == FIN) ? acc_d : value_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= 2'd3;
      cnt_q   <= '0;
      probe_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      probe_q <= probe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign cmp_probe = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign err       = err_q;

endmodule
